// File: rtl/romulus_pkg.sv
// Shared definitions for the Romulus-N x4 TBC control path.
// Holds the scheduler defaults, the FSM state type and the round-constant LFSR step.
package romulus_pkg;

  localparam int         ROUNDS_DEF = 56;
  localparam int         UNROLL_DEF = 4;
  localparam logic [5:0] RC_INIT    = 6'h01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // One step of the 6-bit Skinny round-constant LFSR.
  function automatic logic [5:0] rc_step(input logic [5:0] rc);
    return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction

endpackage

// File: rtl/skinny_rc_lfsr_x4.sv
// Round-constant register for the unrolled Skinny datapath.
// Loads RC_INIT or advances UNROLL LFSR steps in a single cycle.
module skinny_rc_lfsr_x4
  import romulus_pkg::*;
#(
  parameter int UNROLL = UNROLL_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       adv_i,
  output logic [5:0] rc_o
);

  logic [5:0] rc_q;
  logic [5:0] rc_d;
  logic [5:0] rc_adv;

  always_comb begin
    rc_adv = rc_q;
    for (int i = 0; i < UNROLL; i++) begin
      rc_adv = rc_step(rc_adv);
    end
  end

  always_comb begin
    rc_d = rc_q;
    if (load_i) begin
      rc_d = RC_INIT;
    end else if (adv_i) begin
      rc_d = rc_adv;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rc_q <= 6'h00;
    end else begin
      rc_q <= rc_d;
    end
  end

  assign rc_o = rc_q;

endmodule

// File: rtl/skinny_tbc_sched_x4.sv
// Sequencer for one Skinny-128-384 TBC call at UNROLL rounds per cycle:
// LOAD, ROUND x ROUNDS/UNROLL, DONE; all outputs decode registered state.
module skinny_tbc_sched_x4
  import romulus_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF,
  parameter int UNROLL = UNROLL_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       load_o,
  output logic       tk1s_o,
  output logic       round_en_o,
  output logic [5:0] constant_o,
  output logic [3:0] round_idx_o,
  output logic       last_o,
  output logic       done_o
);

  localparam int         CYCLES   = ROUNDS / UNROLL;
  localparam logic [3:0] LAST_IDX = 4'(CYCLES - 1);

  sched_state_e state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic         in_load;
  logic         in_round;
  logic         is_last;
  logic         rc_adv;

  assign in_load  = (state_q == ST_LOAD);
  assign in_round = (state_q == ST_ROUND);
  assign is_last  = in_round && (idx_q == LAST_IDX);
  // constant and round_idx freeze on the final or aborted round cycle
  assign rc_adv   = in_round && !is_last && !abort_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_LOAD;
      ST_LOAD:  state_d = abort_i ? ST_IDLE : ST_ROUND;
      ST_ROUND: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (is_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = start_i ? ST_LOAD : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    if (in_load) begin
      idx_d = 4'd0;
    end else if (rc_adv) begin
      idx_d = idx_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  skinny_rc_lfsr_x4 #(
    .UNROLL(UNROLL)
  ) u_rc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load_i(in_load),
    .adv_i (rc_adv),
    .rc_o  (constant_o)
  );

  assign ready_o     = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy_o      = in_load || in_round;
  assign load_o      = in_load;
  assign tk1s_o      = in_load;
  assign round_en_o  = in_round;
  assign round_idx_o = idx_q;
  assign last_o      = is_last;
  assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_skinny_tbc_sched_x4.sv
// Bench for skinny_tbc_sched_x4: default (56/4) and 40/4 instances driven in lockstep
// and compared every cycle with a call-position reference model.
module tb_skinny_tbc_sched_x4;

  localparam int NA = 14;  // 56/4
  localparam int NB = 10;  // 40/4

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;

  always #5 clk = ~clk;

  logic       a_ready, a_busy, a_load, a_tk1s, a_round_en, a_last, a_done;
  logic [5:0] a_constant;
  logic [3:0] a_idx;
  logic       b_ready, b_busy, b_load, b_tk1s, b_round_en, b_last, b_done;
  logic [5:0] b_constant;
  logic [3:0] b_idx;

  skinny_tbc_sched_x4 dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .ready_o(a_ready), .busy_o(a_busy), .load_o(a_load), .tk1s_o(a_tk1s),
    .round_en_o(a_round_en), .constant_o(a_constant), .round_idx_o(a_idx),
    .last_o(a_last), .done_o(a_done)
  );

  skinny_tbc_sched_x4 #(.ROUNDS(40), .UNROLL(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .ready_o(b_ready), .busy_o(b_busy), .load_o(b_load), .tk1s_o(b_tk1s),
    .round_en_o(b_round_en), .constant_o(b_constant), .round_idx_o(b_idx),
    .last_o(b_last), .done_o(b_done)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  // Position inside a call: 0 idle, 1 load, 2..N+1 round cycles, N+2 done.
  int pos_a = 0;
  int pos_b = 0;
  int load_cnt = 0;
  int done_cnt = 0;

  function automatic logic [5:0] ref_rc(input int steps);
    logic [5:0] r;
    r = 6'h01;
    for (int i = 0; i < steps; i++) r = {r[4:0], r[5] ^ r[4] ^ 1'b1};
    return r;
  endfunction

  function automatic int next_pos(input int p, input int n, input logic s, input logic a, input logic r);
    if (r) return 0;
    if (p == 0) return s ? 1 : 0;
    if (p == 1) return a ? 0 : 2;
    if (p <= n + 1) return a ? 0 : ((p == n + 1) ? n + 2 : p + 1);
    return s ? 1 : 0;
  endfunction

  // {ready, busy, load, tk1s, round_en, last, done}
  function automatic logic [6:0] exp_ctrl(input int p, input int n);
    logic rnd;
    rnd = (p >= 2) && (p <= n + 1);
    return {(p == 0) || (p == n + 2), (p >= 1) && (p <= n + 1), p == 1, p == 1,
            rnd, p == n + 1, p == n + 2};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    check("a_ctrl", {25'd0, a_ready, a_busy, a_load, a_tk1s, a_round_en, a_last, a_done},
          {25'd0, exp_ctrl(pos_a, NA)});
    check("b_ctrl", {25'd0, b_ready, b_busy, b_load, b_tk1s, b_round_en, b_last, b_done},
          {25'd0, exp_ctrl(pos_b, NB)});
    if (pos_a >= 2 && pos_a <= NA + 1) begin
      check("a_const", {26'd0, a_constant}, {26'd0, ref_rc(4 * (pos_a - 2))});
      check("a_idx", {28'd0, a_idx}, pos_a - 2);
    end
    if (pos_b >= 2 && pos_b <= NB + 1) begin
      check("b_const", {26'd0, b_constant}, {26'd0, ref_rc(4 * (pos_b - 2))});
      check("b_idx", {28'd0, b_idx}, pos_b - 2);
    end
  endtask

  task automatic step(input logic s, input logic a, input logic r);
    start = s;
    abort = a;
    rst   = r;
    @(posedge clk);
    pos_a = next_pos(pos_a, NA, s, a, r);
    pos_b = next_pos(pos_b, NB, s, a, r);
    cyc++;
    #1;
    if (a_load) load_cnt++;
    if (a_done) done_cnt++;
    check_all();
  endtask

  task automatic check_reset_values();
    check("rst_a_ctrl", {25'd0, a_ready, a_busy, a_load, a_tk1s, a_round_en, a_last, a_done},
          32'b100_0000);
    check("rst_a_const", {26'd0, a_constant}, 32'h0);
    check("rst_a_idx", {28'd0, a_idx}, 32'h0);
    check("rst_b_const", {26'd0, b_constant}, 32'h0);
    check("rst_b_idx", {28'd0, b_idx}, 32'h0);
  endtask

  logic [5:0] rec_a [16];
  logic [5:0] rec_b [16];
  int t0, k, done_a_off, done_b_off, ren_a, ren_b, last_a;
  int done_offs [$];

  initial begin
    // Reset
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check_reset_values();
    step(1'b0, 1'b0, 1'b0);

    // Single call: latency, constants, last placement
    step(1'b1, 1'b0, 1'b0);
    t0 = cyc - 1;
    done_a_off = -1; done_b_off = -1; ren_a = 0; ren_b = 0; last_a = 0;
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (a_round_en) begin rec_a[a_idx] = a_constant; ren_a++; end
      if (b_round_en) begin rec_b[b_idx] = b_constant; ren_b++; end
      if (a_last) last_a++;
      if (a_done && done_a_off < 0) done_a_off = cyc - t0;
      if (b_done && done_b_off < 0) done_b_off = cyc - t0;
    end
    check("a_done_lat", done_a_off, 16);
    check("b_done_lat", done_b_off, 12);
    check("a_ren_cnt", ren_a, 14);
    check("b_ren_cnt", ren_b, 10);
    check("a_last_cnt", last_a, 1);
    check("a_c0", {26'd0, rec_a[0]}, 32'h01);
    check("a_c1", {26'd0, rec_a[1]}, 32'h1F);
    check("a_c2", {26'd0, rec_a[2]}, 32'h37);
    check("a_c3", {26'd0, rec_a[3]}, 32'h39);
    check("a_c13", {26'd0, rec_a[13]}, 32'h19);
    check("b_c9", {26'd0, rec_b[9]}, 32'h1B);

    // start held high for three back-to-back calls
    step(1'b1, 1'b0, 1'b0);
    t0 = cyc - 1;
    if (a_done) done_offs.push_back(cyc - t0);
    for (int i = 0; i < 48; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (a_done) done_offs.push_back(cyc - t0);
    end
    check("held_done_cnt", done_offs.size(), 3);
    if (done_offs.size() == 3) begin
      check("held_done1", done_offs[0], 16);
      check("held_done2", done_offs[1], 32);
      check("held_done3", done_offs[2], 48);
    end
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);

    // Abort in round cycle 5
    step(1'b1, 1'b0, 1'b0);
    k = 0;
    while (!(a_round_en && a_idx == 4'd5) && k < 20) begin
      step(1'b0, 1'b0, 1'b0);
      k++;
    end
    check("abort_reach", k < 20, 1);
    done_cnt = 0;
    step(1'b0, 1'b1, 1'b0);
    check("abort_ren", a_round_en, 0);
    check("abort_ready", a_ready, 1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
    check("abort_no_done", done_cnt, 0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("restart_const", {26'd0, a_constant}, 32'h01);
    check("restart_idx", {28'd0, a_idx}, 32'h0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);

    // start pulsed during every busy cycle of one call
    load_cnt = 0; done_cnt = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 22; i++) step(a_busy, 1'b0, 1'b0);
    check("busy_start_loads", load_cnt, 1);
    check("busy_start_dones", done_cnt, 1);

    // Reset in the middle of a call
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check_reset_values();
    step(1'b0, 1'b0, 1'b0);

    // Random start/abort/reset traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/skinny_tbc_sched_x4.md
# skinny_tbc_sched_x4

Round scheduler for the 4-rounds-per-cycle Skinny-128-384 tweakable block cipher inside the Romulus-N x4 datapath. The API controller issues one start pulse per TBC call. This block then sequences the call:

- loads the state and tweakey registers,
- steps the round datapath for ROUNDS/UNROLL cycles,
- generates the 6-bit round constant for each cycle,
- signals completion.

It sits between the API controller and the cipher datapath, and it owns the round-constant LFSR.

## Interface
Parameters:
- ROUNDS, 56, Skinny rounds per TBC call; must be a multiple of UNROLL.
- UNROLL, 4, rounds evaluated per clock cycle.

Ports:
- clk  in  1  system clock. Single clock domain.
- rst  in  1  reset. Synchronous, active-high.
- start  in  1  request one TBC call. Accepted only while ready=1.
- abort  in  1  cancel the call in progress. Synchronous.
- ready  out  1  scheduler can accept start.
- busy  out  1  call in progress (LOAD or ROUND).
- load  out  1  datapath captures plaintext block and TK1/TK2/TK3.
- tk1s  out  1  TK1 mux selects fresh counter/domain input. Otherwise selects the round-updated TK1.
- round_en  out  1  datapath state and tweakey registers advance UNROLL rounds.
- constant  out  6  round constant of the first of the UNROLL rounds in this cycle. The datapath derives the other three combinationally.
- round_idx  out  4  cycle index within the call, 0..ROUNDS/UNROLL-1.
- last  out  1  current ROUND cycle is the final one.
- done  out  1  one-cycle pulse: datapath output holds the valid ciphertext.

## Operation
- FSM states: IDLE, LOAD, ROUND, DONE.
- IDLE:
  - ready=1.
  - start=1 → LOAD.
- LOAD (one cycle):
  - load=1, tk1s=1, busy=1.
  - rc register set to 0x01.
  - round_idx set to 0.
  - Next state: ROUND.
- ROUND:
  - round_en=1, busy=1, constant=rc.
  - Each cycle, rc advances UNROLL LFSR steps. Step: rc' = {rc[4:0], rc[5]^rc[4]^1}.
  - round_idx increments by 1 per cycle.
  - last=1 when round_idx = ROUNDS/UNROLL-1. That cycle is followed by DONE.
- DONE (one cycle):
  - done=1, ready=1.
  - start=1 → LOAD (back-to-back call, no idle bubble).
  - Otherwise → IDLE.
- Constant sequence for ROUNDS=56, UNROLL=4:
  - Cycles 0,1,2,3: 0x01, 0x1F, 0x37, 0x39.
  - Cycle 13: 0x19.
  - Constant of the final Skinny round (round 56): 0x0A, derived inside the datapath.
- abort:
  - In LOAD or ROUND: → IDLE next cycle. No done pulse. round_en and load are low in that next cycle.
  - In IDLE or DONE: ignored.
  - Abort has priority over start in the same cycle.
- start while busy: ignored. It is not queued.
- rst: has priority over all inputs. Forces IDLE from any state, including mid-call.

## Timing
- Reset values:
  - ready=1.
  - busy=0, load=0, tk1s=0, round_en=0, last=0, done=0.
  - constant=0x00, round_idx=0.
  - FSM=IDLE.
- All outputs are registered-state decodes. There is no combinational path from any input to any output.
- start accepted at edge t gives:
  - load high in cycle t+1.
  - round_en high in cycles t+2..t+15.
  - done high in cycle t+16.
- Latency from start to done: ROUNDS/UNROLL+2 cycles (16 at default parameters).
- Throughput: one call per ROUNDS/UNROLL+2 cycles with start held high continuously.
- constant and round_idx hold their last value outside ROUND. Consumers use them only when round_en=1.

## Structure
- Shared package romulus_pkg holds:
  - ROUNDS and UNROLL defaults.
  - RC_INIT = 6'h01.
  - FSM state enum.
  - Function rc_step(rc) implementing one LFSR step.
- One sub-module: skinny_rc_lfsr_x4. It holds the 6-bit rc register with load and advance-by-UNROLL inputs, built as a combinational unroll of rc_step.
- FSM and round counter live in the top module.

## Test plan
- Reset, then a single start pulse:
  - load high at t+1.
  - round_en high for 14 cycles with constants 0x01, 0x1F, 0x37, 0x39 … 0x19.
  - last high only in cycle 13.
  - done high at t+16; ready high at t+16.
- start held high for 3 calls:
  - done at t+16, t+32, t+48.
  - load reasserts in the cycle immediately after each done.
- abort in ROUND cycle 5:
  - Next cycle: IDLE, round_en=0, no done.
  - A following start restarts with constant 0x01 and round_idx 0.
- start pulsed in every busy cycle: exactly one done per accepted start, and no extra load.
- rst asserted mid-ROUND: every output returns to its reset value on the next edge.
- Parameter sweep ROUNDS=40, UNROLL=4: 10 round_en cycles, done at t+12, cycle-9 constant equal to round-37 constant (0x1B).
